// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT
  } rx_state_t;

  // Even parity of a data word; callers zero-extend narrower words, which
  // leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; free-running every clk.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops; both reset to the line's idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, even parity, one stop.
// Latency: data_valid pulses ~mid stop bit (+2 clk synchronizer delay).
// Backpressure: none; data_out is simply overwritten by the next completed frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_WIDTH + 1);

  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  rx_state_t             state_q, state_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  rx_sync;
  logic                  rx_prev;
  logic                  frame_done;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx_serial),
    .q    (rx_sync)
  );

  // Previous tick's line sample; tracked in every state so a line that
  // stays low after a frame never looks like a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
    end else if (sample_tick) begin
      rx_prev <= rx_sync;
    end
  end

  // State, counters and shift register advance only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
    end
  end

  // Next-state logic: mid-bit check of the start bit, then full-bit sampling.
  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state_d  = START_BIT;
            os_cnt_d = '0;
          end
        end
        START_BIT: begin
          if (os_cnt_q == OS_MID) begin
            if (rx_sync) begin
              // Line went back high before mid-bit: treat as a glitch.
              state_d = IDLE;
            end else begin
              state_d   = DATA_BITS;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        DATA_BITS: begin
          if (os_cnt_q == OS_LAST) begin
            shift_d   = {rx_sync, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + BC_ONE;
            os_cnt_d  = '0;
            if (bit_cnt_q == BC_LAST) begin
              state_d = PARITY_BIT;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        PARITY_BIT: begin
          if (os_cnt_q == OS_LAST) begin
            par_d    = rx_sync;
            os_cnt_d = '0;
            state_d  = STOP_BIT;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        STOP_BIT: begin
          if (os_cnt_q == OS_LAST) begin
            frame_done = 1'b1;
            os_cnt_d   = '0;
            state_d    = IDLE;
          end else begin
            os_cnt_d = os_cnt_q + OS_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Result registers: loaded together at stop-bit sampling; data_valid is
  // a single-clk pulse regardless of tick spacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid <= frame_done;
      if (frame_done) begin
        data_out     <= shift_q;
        parity_error <= even_parity(32'(shift_q)) ^ par_q;
        frame_error  <= ~rx_sync;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: sample_tick pulses per bit period; SHALL be an even number of at least 4.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sample_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-006 rx_serial  input  1  asynchronous serial line; idles high.
REQ-007 data_out  output  DATA_WIDTH  last received data word; held until the next frame completes.
REQ-008 data_valid  output  1  one-clk pulse when a frame completes.
REQ-009 parity_error  output  1  set when the last frame's parity check failed; updated only with data_valid.
REQ-010 frame_error  output  1  set when the last frame's stop bit sampled low; updated only with data_valid.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, even-parity bit (equal to the XOR of the data bits), one stop bit (1).
REQ-013 rx_serial SHALL pass through a 2-flop synchronizer (rx_sync) before any use; the synchronizer resets to 1.
REQ-014 States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT; all state, counter and sampling updates occur only on clk edges where sample_tick=1, except the data_valid clear.
REQ-015 IDLE: a falling edge of rx_sync (previous sample 1, current sample 0, both taken on sample_tick) SHALL move to START_BIT and clear os_cnt; a line held low SHALL NOT start a new frame.
REQ-016 START_BIT: os_cnt increments each tick; at os_cnt==OVERSAMPLE/2-1, rx_sync=1 is a glitch that SHALL return to IDLE with no outputs changed; rx_sync=0 SHALL clear os_cnt and bit_cnt and move to DATA_BITS.
REQ-017 DATA_BITS: at os_cnt==OVERSAMPLE-1, sample rx_sync into the shift register MSB, shift right, increment bit_cnt and clear os_cnt; after DATA_WIDTH samples, move to PARITY_BIT.
REQ-018 PARITY_BIT: at os_cnt==OVERSAMPLE-1, capture the parity bit and move to STOP_BIT.
REQ-019 STOP_BIT: at os_cnt==OVERSAMPLE-1, in the same clk load data_out from the shift register, set parity_error = XOR(data bits, parity bit), set frame_error = ~rx_sync, pulse data_valid, and go to IDLE.
REQ-020 data_valid SHALL be high for exactly one clk cycle, even if sample_tick is asserted on consecutive clocks.
REQ-021 A frame with a frame error or a parity error SHALL still load data_out and pulse data_valid.
REQ-022 Back-to-back frames (stop bit followed immediately by a start bit) SHALL be received without loss.
REQ-023 Counter widths: os_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_WIDTH+1) bits; neither counter wraps within a frame.

Reset
REQ-024 With rst_n=0, outputs SHALL be: data_out=0, data_valid=0, parity_error=0, frame_error=0, busy=0; state=IDLE; counters=0; synchronizer and previous-sample register=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no data_valid; the next complete frame after release SHALL be received correctly.

Structure
REQ-026 Package uart_pkg SHALL hold the rx state enum, the parity function, and the default DATA_WIDTH and OVERSAMPLE constants.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter.

Verification
REQ-028 Send 0xA5 with parity 0 and stop 1 -> data_out=0xA5, one data_valid pulse, parity_error=0, frame_error=0.
REQ-029 Send 0x3C with parity bit 1 -> data_out=0x3C, parity_error=1, frame_error=0.
REQ-030 Send 0x81 with parity 0 and stop bit 0 -> data_out=0x81, frame_error=1; with the line held low afterwards, no further data_valid occurs until the line returns high and falls again.
REQ-031 Drive rx_serial low for 4 sample ticks, then high -> busy pulses, returns to IDLE, no data_valid.
REQ-032 Send 0x00 and 0xFF back-to-back -> two data_valid pulses with data_out 0x00 then 0xFF and parity_error=0 both times.
REQ-033 Assert rst_n low during the 4th data bit of 0x5A, release, then send 0x5A -> first frame yields no data_valid, second frame yields data_out=0x5A.
